sdf_fft_ctrl: RTL and testbench

- Sequencer for the radix-2^2 single-path delay-feedback (SDF) FFT pipeline.
- Each stage of the pipeline is one BF I (buffer N/2/4^s) and one BF II (buffer N/4/4^s). A twiddle multiplier sits between consecutive stages.
- Generates the pipeline enable, the per-stage BF control bits, the twiddle ROM addresses, the output frame markers and a flush/drain sequence.
- Pure control block: it does not touch any sample data.

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/sdf_fft_ctrl_if.sv | 35 +++
 rtl/fft_tw_addr_gen.sv | 27 ++
 rtl/sdf_fft_ctrl.sv | 140 ++++++++++++++
 tb/tb_sdf_fft_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, delay-point arithmetic and state encoding for the
// radix-2^2 SDF FFT sequencer.
package fft_pkg;

    // Default configuration (16-point, two radix-2^2 stages).
    localparam int LOG2N   = 4;
    localparam int LATENCY = 20;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // End-to-end pipeline latency in en-ticks.
    function automatic int latency(int n, int stages, int bf_lat, int tw_lat);
        return (n - 1) + 2 * stages * bf_lat + (stages - 1) * tw_lat;
    endfunction

    // Delay of the BF I input of stage s: sum of all earlier stage delays.
    function automatic int d_bfi(int n, int s, int bf_lat, int tw_lat);
        int d;
        d = 0;
        for (int k = 0; k < s; k++)
            d = d + (n >> (2 * k + 1)) + (n >> (2 * k + 2)) + 2 * bf_lat + tw_lat;
        return d;
    endfunction

    // BF II input of stage s sits behind the BF I buffer (N/2/4^s) and its register.
    function automatic int d_bfii(int n, int s, int bf_lat, int tw_lat);
        return d_bfi(n, s, bf_lat, tw_lat) + (n >> (2 * s + 1)) + bf_lat;
    endfunction

    // Twiddle multiplier input of stage s sits behind the BF II buffer (N/4/4^s).
    function automatic int d_tw(int n, int s, int bf_lat, int tw_lat);
        return d_bfii(n, s, bf_lat, tw_lat) + (n >> (2 * s + 2)) + bf_lat;
    endfunction

    // 2-bit bit reversal of the quarter index.
    function automatic logic [1:0] rev2(logic [1:0] q);
        return {q[0], q[1]};
    endfunction

endpackage

// File: rtl/sdf_fft_ctrl_if.sv
// Control bundle between the SDF FFT sequencer and the datapath/source.
interface sdf_fft_ctrl_if #(
    parameter int N_POINTS = 16,
    parameter int STAGES   = 2
);
    localparam int N_LOG2 = $clog2(N_POINTS);

    logic                          in_valid;
    logic                          in_ready;
    logic                          flush;
    logic                          en;
    logic                          in_zero;
    logic [STAGES-1:0]             ctrl1;
    logic [STAGES-1:0]             ctrl2;
    logic [STAGES-1:0]             bfi_ctrl;
    logic [(STAGES-1)*N_LOG2-1:0]  tw_addr;
    logic                          out_valid;
    logic                          out_sof;
    logic                          out_eof;
    logic                          busy;

    // Source / datapath side.
    modport master (
        output in_valid, flush,
        input  in_ready, en, in_zero, ctrl1, ctrl2, bfi_ctrl, tw_addr,
               out_valid, out_sof, out_eof, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, flush,
        output in_ready, en, in_zero, ctrl1, ctrl2, bfi_ctrl, tw_addr,
               out_valid, out_sof, out_eof, busy
    );
endinterface

// File: rtl/fft_tw_addr_gen.sv
// Twiddle exponent for one inter-stage multiplier, from the local sample
// index seen at that multiplier.
module fft_tw_addr_gen
    import fft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int STAGE    = 0
) (
    input  logic                          i_live,
    input  logic [$clog2(N_POINTS)-1:0]   i_idx,
    output logic [$clog2(N_POINTS)-1:0]   o_addr
);
    localparam int N_LOG2 = $clog2(N_POINTS);
    localparam int LOG2L  = N_LOG2 - 2 * STAGE;   // sub-transform length L = N/4^s

    logic [1:0]        w_q;
    logic [N_LOG2-1:0] w_r;
    logic [N_LOG2-1:0] w_prod;

    // q picks the quarter of the L-block, r the position inside that quarter.
    assign w_q    = i_idx[LOG2L-1 -: 2];
    assign w_r    = i_idx & N_LOG2'((1 << (LOG2L - 2)) - 1);
    // Truncation to N_LOG2 bits gives the mod-N wrap for free.
    assign w_prod = (N_LOG2'(rev2(w_q)) * w_r) << (2 * STAGE);
    assign o_addr = i_live ? w_prod : '0;

endmodule

// File: rtl/sdf_fft_ctrl.sv
// Sequencer for a radix-2^2 single-path delay-feedback FFT: accepts samples,
// drives the shared advance strobe, per-stage butterfly selects, twiddle
// addresses, output frame markers and a zero-padded drain on flush.
module sdf_fft_ctrl
    import fft_pkg::*;
#(
    parameter int N_POINTS   = 16,
    parameter int STAGES     = 2,
    parameter int BF_REG_LAT = 1,
    parameter int TW_MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    sdf_fft_ctrl_if.slave io_bus
);
    localparam int N_LOG2 = $clog2(N_POINTS);
    localparam int N_LAT  = latency(N_POINTS, STAGES, BF_REG_LAT, TW_MUL_LAT);
    localparam int FW     = $clog2(N_LAT + 1);
    localparam int DW     = $clog2(N_POINTS + N_LAT);

    if (N_POINTS < 16 || (N_POINTS & (N_POINTS - 1)) != 0 || (N_LOG2 % 2) != 0) begin : g_bad_size
        $error("sdf_fft_ctrl: N_POINTS must be a power of 4 and at least 16");
    end
    if (STAGES != N_LOG2 / 2) begin : g_bad_stages
        $error("sdf_fft_ctrl: STAGES must equal log4(N_POINTS)");
    end

    state_t            r_state;
    logic [N_LOG2-1:0] r_in_idx;
    logic [FW-1:0]     r_fill;
    logic [DW-1:0]     r_drain;

    logic              w_en;
    logic [N_LOG2-1:0] w_idx_next;
    logic [N_LOG2-1:0] w_pad;
    logic [N_LOG2-1:0] w_out_idx;

    // Advance strobe: forced during drain, otherwise follows the accepted sample.
    always_comb begin
        w_en = io_bus.in_valid;
        if (r_state == FLUSH)
            w_en = 1'b1;
    end

    assign w_idx_next = w_en ? r_in_idx + 1'b1 : r_in_idx;
    assign w_pad      = '0 - w_idx_next;   // samples still missing from the current frame

    // Mode sequencing plus the input index, fill and drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_in_idx <= '0;
            r_fill   <= '0;
            r_drain  <= '0;
        end else begin
            if (w_en) begin
                r_in_idx <= w_idx_next;
                if (r_fill != FW'(N_LAT))
                    r_fill <= r_fill + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid)
                        r_state <= RUN;
                end
                RUN: begin
                    if (io_bus.flush) begin
                        r_state <= FLUSH;
                        // Counts down to 0 inclusive, so load one less than the tick count.
                        r_drain <= DW'(w_pad) + DW'(N_LAT - 1);
                    end
                end
                FLUSH: begin
                    if (r_drain == '0) begin
                        r_state  <= IDLE;
                        r_in_idx <= '0;
                        r_fill   <= '0;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-stage butterfly selects and inter-stage twiddle addresses.
    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int DB1 = d_bfi(N_POINTS, gi, BF_REG_LAT, TW_MUL_LAT);
        localparam int DB2 = d_bfii(N_POINTS, gi, BF_REG_LAT, TW_MUL_LAT);

        logic [N_LOG2-1:0] w_idx1;
        logic [N_LOG2-1:0] w_idx2;
        logic              w_live1;
        logic              w_live2;

        assign w_idx1  = r_in_idx - N_LOG2'(DB1 % N_POINTS);
        assign w_idx2  = r_in_idx - N_LOG2'(DB2 % N_POINTS);
        // Before the first sample reaches a point, hold its buffer in fill mode.
        assign w_live1 = (r_fill >= FW'(DB1));
        assign w_live2 = (r_fill >= FW'(DB2));

        assign io_bus.bfi_ctrl[gi] = w_live1 & w_idx1[N_LOG2-1-2*gi];
        assign io_bus.ctrl1[gi]    = w_live2 & w_idx2[N_LOG2-1-2*gi];
        assign io_bus.ctrl2[gi]    = w_live2 & w_idx2[N_LOG2-2-2*gi];

        if (gi < STAGES - 1) begin : g_tw
            localparam int DT = d_tw(N_POINTS, gi, BF_REG_LAT, TW_MUL_LAT);

            logic [N_LOG2-1:0] w_idx_t;
            logic              w_live_t;
            logic [N_LOG2-1:0] w_addr;

            assign w_idx_t  = r_in_idx - N_LOG2'(DT % N_POINTS);
            assign w_live_t = (r_fill >= FW'(DT));

            fft_tw_addr_gen #(
                .N_POINTS (N_POINTS),
                .STAGE    (gi)
            ) u_tw (
                .i_live (w_live_t),
                .i_idx  (w_idx_t),
                .o_addr (w_addr)
            );

            assign io_bus.tw_addr[gi*N_LOG2 +: N_LOG2] = w_addr;
        end
    end

    assign w_out_idx        = r_in_idx - N_LOG2'(N_LAT % N_POINTS);
    assign io_bus.en        = w_en;
    assign io_bus.in_ready  = (r_state != FLUSH);
    assign io_bus.in_zero   = (r_state == FLUSH);
    assign io_bus.busy      = (r_state != IDLE);
    assign io_bus.out_valid = w_en & (r_fill == FW'(N_LAT));
    assign io_bus.out_sof   = io_bus.out_valid & (w_out_idx == '0);
    assign io_bus.out_eof   = io_bus.out_valid & (w_out_idx == '1);

endmodule

// File: tb/tb_sdf_fft_ctrl.sv
// Bench for the SDF FFT sequencer: per-cycle comparison against a tick-count
// model plus hand-computed checkpoints from the 16-point reference timeline.
module tb_sdf_fft_ctrl;
    localparam int N     = 16;
    localparam int S     = 2;
    localparam int LOG2N = 4;
    localparam int LAT   = 20;

    int dbfi  [S]   = '{0, 15};
    int dbfii [S]   = '{9, 18};
    int dtw   [S-1] = '{14};

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    sdf_fft_ctrl_if #(.N_POINTS(N), .STAGES(S)) bus ();

    sdf_fft_ctrl #(
        .N_POINTS   (N),
        .STAGES     (S),
        .BF_REG_LAT (1),
        .TW_MUL_LAT (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Control bit b of the local index at delay point d, k ticks into the frame.
    function automatic int bit_at(int k, int d, int b);
        if (k < d) return 0;
        return (((k - d) % N) >> b) & 1;
    endfunction

    function automatic int tw_of(int k, int s);
        int m, l, q, r, rq;
        if (k < dtw[s]) return 0;
        m  = (k - dtw[s]) % N;
        l  = N >> (2 * s);
        q  = (m % l) / (l / 4);
        r  = m % (l / 4);
        rq = ((q & 1) << 1) | (q >> 1);
        return (rq * r * (1 << (2 * s))) % N;
    endfunction

    // Model: mode 0 idle / 1 run / 2 flush, k = en-ticks since frame start.
    int m_mode = 0, m_k = 0, m_left = 0;
    bit armed = 1'b0;
    int e_en, e_bfi, e_c1, e_c2, e_tw, e_ov, e_sof, e_eof;

    always @(negedge clk) begin
        e_en  = (m_mode == 2 || bus.in_valid === 1'b1) ? 1 : 0;
        e_bfi = 0; e_c1 = 0; e_c2 = 0; e_tw = 0;
        for (int s = 0; s < S; s++) begin
            e_bfi |= bit_at(m_k, dbfi[s],  LOG2N - 1 - 2 * s) << s;
            e_c1  |= bit_at(m_k, dbfii[s], LOG2N - 1 - 2 * s) << s;
            e_c2  |= bit_at(m_k, dbfii[s], LOG2N - 2 - 2 * s) << s;
        end
        for (int s = 0; s < S - 1; s++)
            e_tw |= tw_of(m_k, s) << (LOG2N * s);
        e_ov  = (e_en == 1 && m_k >= LAT) ? 1 : 0;
        e_sof = (e_ov == 1 && (m_k - LAT) % N == 0) ? 1 : 0;
        e_eof = (e_ov == 1 && (m_k - LAT) % N == N - 1) ? 1 : 0;

        if (armed) begin
            chk("en",        bus.en,        e_en);
            chk("in_ready",  bus.in_ready,  (m_mode != 2) ? 1 : 0);
            chk("in_zero",   bus.in_zero,   (m_mode == 2) ? 1 : 0);
            chk("busy",      bus.busy,      (m_mode != 0) ? 1 : 0);
            chk("bfi_ctrl",  bus.bfi_ctrl,  e_bfi);
            chk("ctrl1",     bus.ctrl1,     e_c1);
            chk("ctrl2",     bus.ctrl2,     e_c2);
            chk("tw_addr",   bus.tw_addr,   e_tw);
            chk("out_valid", bus.out_valid, e_ov);
            chk("out_sof",   bus.out_sof,   e_sof);
            chk("out_eof",   bus.out_eof,   e_eof);
            if (e_ov == 1)
                $display("out sample idx=%0d sof=%0d eof=%0d zero_in=%0d",
                         (m_k - LAT) % N, e_sof, e_eof, (m_mode == 2) ? 1 : 0);
        end

        if (rst) begin
            m_mode = 0; m_k = 0; m_left = 0;
            armed  = 1'b1;
        end else begin
            case (m_mode)
                0: begin
                    if (e_en == 1) begin m_k++; m_mode = 1; end
                end
                1: begin
                    if (e_en == 1) m_k++;
                    if (bus.flush === 1'b1) begin
                        m_mode = 2;
                        m_left = ((N - (m_k % N)) % N) + LAT;
                    end
                end
                default: begin
                    m_k++;
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_k = 0; end
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    int n_fl, n_pz, n_ov, n_ov_pad;

    initial begin
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;

        // Idle after reset.
        do_reset();
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy",  bus.busy, 0);
            chk("idle_ready", bus.in_ready, 1);
            chk("idle_en",    bus.en, 0);
            chk("idle_ctrl",  {bus.bfi_ctrl, bus.ctrl1, bus.ctrl2, bus.tw_addr, bus.out_valid}, 0);
            cyc();
        end

        // Continuous input: reference timeline checkpoints.
        do_reset();
        bus.in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 7)  chk("bfi0_t7",  bus.bfi_ctrl[0], 0);
            if (t == 8)  chk("bfi0_t8",  bus.bfi_ctrl[0], 1);
            if (t == 15) chk("bfi0_t15", bus.bfi_ctrl[0], 1);
            if (t == 16) chk("bfi0_t16", bus.bfi_ctrl[0], 0);
            if (t == 12) chk("c2_0_t12", bus.ctrl2[0], 0);
            if (t == 13) chk("c2_0_t13", bus.ctrl2[0], 1);
            if (t == 17) chk("c2_0_t17", bus.ctrl2[0], 0);
            if (t == 16) chk("bfi1_t16", bus.bfi_ctrl[1], 0);
            if (t == 17) chk("bfi1_t17", bus.bfi_ctrl[1], 1);
            if (t == 19) chk("tw_t19",   bus.tw_addr, 2);
            if (t == 21) chk("tw_t21",   bus.tw_addr, 6);
            if (t == 24) chk("tw_t24",   bus.tw_addr, 2);
            if (t == 27) chk("tw_t27",   bus.tw_addr, 3);
            if (t == 19) chk("ov_t19",   bus.out_valid, 0);
            if (t == 20) chk("sof_t20",  bus.out_sof, 1);
            if (t == 35) chk("eof_t35",  bus.out_eof, 1);
            cyc();
        end
        bus.in_valid = 1'b0;

        // Three-cycle input gap at cycles 10..12.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            bus.in_valid = (c < 10 || c >= 13);
            @(negedge clk);
            if (c >= 10 && c < 13) chk("gap_en", bus.en, 0);
            if (c == 11) chk("gap_bfi_hold", bus.bfi_ctrl[0], 1);
            if (c == 20) chk("gap_sof_c20", bus.out_sof, 0);
            if (c == 23) chk("gap_sof_c23", bus.out_sof, 1);
            cyc();
        end
        bus.in_valid = 1'b0;

        // Flush after 20 accepted samples.
        do_reset();
        bus.in_valid = 1'b1;
        repeat (20) cyc();
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_req_en", bus.en, 0);
        cyc();
        bus.flush = 1'b0;
        n_fl = 0; n_pz = 0; n_ov = 0; n_ov_pad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n_fl++;
            if (bus.in_zero && !bus.in_ready && bus.en) n_pz++;
            if (bus.out_valid) begin
                n_ov++;
                if (c < 12) n_ov_pad++;
            end
            cyc();
        end
        chk("flush_len",    n_fl, 32);
        chk("flush_zero",   n_pz, 32);
        chk("flush_ov_pad", n_ov_pad, 12);
        chk("flush_ov_all", n_ov, 32);
        chk("flush_ready",  bus.in_ready, 1);
        cyc();

        // Reset in the middle of a drain, then a fresh frame.
        do_reset();
        bus.in_valid = 1'b1;
        repeat (5) cyc();
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        chk("mid_flush_busy", bus.busy, 1);
        chk("mid_flush_zero", bus.in_zero, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_zero",  bus.in_zero, 0);
        chk("rst_en",    bus.en, 0);
        chk("rst_ready", bus.in_ready, 1);
        cyc();
        bus.in_valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 7) chk("restart_bfi0_t7", bus.bfi_ctrl[0], 0);
            if (t == 8) chk("restart_bfi0_t8", bus.bfi_ctrl[0], 1);
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
